// File: rtl/param_proc_core.sv
// ---------------------------------------------------------------------------
// param_proc_core
//
// Multi-cycle register-file processor with a parametrised datapath. One
// instruction at a time is accepted through a start/busy/done handshake and
// executed over the T1..T3 states of a control FSM. All data movement goes
// through a single multiplexed internal bus.
//
// Parameters
//   WIDTH     datapath / register width in bits (>= 2)
//   NUM_REGS  number of general registers, power of two (>= 2)
//   SEL_W     register-select width, derived from NUM_REGS
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    instruction request, sampled only while idle
//   func     opcode: 000 LOAD, 001 MOVE, 010 ADD, 011 SUB, 100 XOR, else illegal
//   rx, ry   destination / first operand and second operand register selects
//   data_in  immediate value for LOAD
//   busy     high while an instruction is in progress
//   done     one-cycle completion pulse (registered)
//   err      qualifies done: 1 = illegal opcode
//   carry    ADD carry-out / SUB no-borrow / 0 after XOR
//   zero     last ALU result was zero
//   bus_out  current internal bus value (0 when nothing drives it)
//   rd_sel   debug read select
//   rd_data  combinational contents of R[rd_sel]
// ---------------------------------------------------------------------------
module param_proc_core #(
    parameter int WIDTH    = 3,
    parameter int NUM_REGS = 4,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic [SEL_W-1:0] rx,
    input  logic [SEL_W-1:0] ry,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             carry,
    output logic             zero,
    output logic [WIDTH-1:0] bus_out,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    state_t             state_reg;

    // Instruction register, captured at the accepting edge.
    logic [2:0]         ir_func_reg;
    logic [SEL_W-1:0]   ir_rx_reg;
    logic [SEL_W-1:0]   ir_ry_reg;
    logic [WIDTH-1:0]   ir_data_reg;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   g_reg;
    logic               carry_reg;
    logic               zero_reg;
    logic               done_reg;
    logic               err_reg;

    logic [WIDTH-1:0]   regs_reg [NUM_REGS];

    logic [WIDTH-1:0]   bus;
    logic               is_alu_op;
    logic               wr_en;
    logic [NUM_REGS-1:0] reg_we;

    logic [WIDTH:0]     alu_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;

    assign is_alu_op = (ir_func_reg == OP_ADD) || (ir_func_reg == OP_SUB) ||
                       (ir_func_reg == OP_XOR);

    // ---------------------------------------------------------------------
    // Internal bus multiplexer: exactly one source per state, 0 otherwise.
    // ---------------------------------------------------------------------
    always_comb begin
        bus = '0;
        case (state_reg)
            T1: begin
                case (ir_func_reg)
                    OP_LOAD:                bus = ir_data_reg;
                    OP_MOVE:                bus = regs_reg[ir_ry_reg];
                    OP_ADD, OP_SUB, OP_XOR: bus = regs_reg[ir_rx_reg];
                    default:                bus = '0;
                endcase
            end
            T2:      bus = regs_reg[ir_ry_reg];
            T3:      bus = g_reg;
            default: bus = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // ALU: operand A from the A register, operand B from the bus (R[ry] in T2).
    // SUB is A + ~B + 1 so the extra bit is the no-borrow flag (A >= B).
    // ---------------------------------------------------------------------
    always_comb begin
        alu_ext = '0;
        case (ir_func_reg)
            OP_ADD:  alu_ext = {1'b0, a_reg} + {1'b0, bus};
            OP_SUB:  alu_ext = {1'b0, a_reg} + {1'b0, ~bus} + (WIDTH+1)'(1);
            default: alu_ext = {1'b0, a_reg ^ bus};
        endcase
    end

    assign alu_res   = alu_ext[WIDTH-1:0];
    assign alu_carry = alu_ext[WIDTH];

    // ---------------------------------------------------------------------
    // Register file: written from the bus in T1 (LOAD/MOVE) or T3 (ALU).
    // ---------------------------------------------------------------------
    assign wr_en = ((state_reg == T1) &&
                    ((ir_func_reg == OP_LOAD) || (ir_func_reg == OP_MOVE))) ||
                   (state_reg == T3);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
            assign reg_we[gi] = wr_en && (ir_rx_reg == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_we[i]) begin
                    regs_reg[i] <= bus;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered done/err and flag registers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ir_func_reg <= '0;
            ir_rx_reg   <= '0;
            ir_ry_reg   <= '0;
            ir_data_reg <= '0;
            a_reg       <= '0;
            g_reg       <= '0;
            carry_reg   <= 1'b0;
            zero_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        ir_func_reg <= func;
                        ir_rx_reg   <= rx;
                        ir_ry_reg   <= ry;
                        ir_data_reg <= data_in;
                        state_reg   <= T1;
                    end
                end
                T1: begin
                    if (is_alu_op) begin
                        a_reg     <= bus;
                        state_reg <= T2;
                    end else begin
                        // LOAD/MOVE complete here; anything else is illegal.
                        done_reg  <= 1'b1;
                        err_reg   <= (ir_func_reg != OP_LOAD) &&
                                     (ir_func_reg != OP_MOVE);
                        state_reg <= IDLE;
                    end
                end
                T2: begin
                    g_reg     <= alu_res;
                    carry_reg <= (ir_func_reg == OP_XOR) ? 1'b0 : alu_carry;
                    zero_reg  <= (alu_res == '0);
                    state_reg <= T3;
                end
                T3: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign err     = err_reg;
    assign carry   = carry_reg;
    assign zero    = zero_reg;
    assign bus_out = bus;
    assign rd_data = regs_reg[rd_sel];

endmodule

// File: tb/tb_param_proc_core.sv
// ---------------------------------------------------------------------------
// tb_param_proc_core
//
// Directed testbench for param_proc_core (WIDTH=3, NUM_REGS=4). Each task
// drives one scenario and checks outputs on the falling edge, away from the
// active rising edge. Expected values are hand-computed modulo 8.
// ---------------------------------------------------------------------------
module tb_param_proc_core;

    localparam int WIDTH    = 3;
    localparam int NUM_REGS = 4;
    localparam int SEL_W    = 2;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       func;
    logic [SEL_W-1:0] rx;
    logic [SEL_W-1:0] ry;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic             err;
    logic             carry;
    logic             zero;
    logic [WIDTH-1:0] bus_out;
    logic [SEL_W-1:0] rd_sel;
    logic [WIDTH-1:0] rd_data;

    int total = 0;
    int bad   = 0;

    param_proc_core #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .rx(rx), .ry(ry),
        .data_in(data_in), .busy(busy), .done(done), .err(err),
        .carry(carry), .zero(zero), .bus_out(bus_out),
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Compare all four registers through the debug port against an expected set.
    task automatic check_regs(input string name, input logic [2:0] e0,
                              input logic [2:0] e1, input logic [2:0] e2,
                              input logic [2:0] e3);
        logic [2:0] exp_v [4];
        exp_v = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            rd_sel = SEL_W'(i);
            #1;
            total++;
            if (rd_data !== exp_v[i]) begin
                bad++;
                $display("FAIL %s R%0d: got %0d expected %0d", name, i, rd_data, exp_v[i]);
            end
            $display("%s: R%0d = %0d", name, i, rd_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; func = '0; rx = '0; ry = '0; data_in = '0; rd_sel = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, err, carry, zero} !== 5'b00000 || bus_out !== 3'd0) begin
            bad++;
            $display("FAIL reset_outputs: got b/d/e/c/z=%b bus=%0d expected 00000 bus=0",
                     {busy, done, err, carry, zero}, bus_out);
        end
        check_regs("reset", 3'd0, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Four LOADs with start held high: one done every two cycles.
    task automatic test_load_b2b();
        logic [2:0] vals [4];
        vals = '{3'd3, 3'd5, 3'd4, 3'd1};
        @(negedge clk);
        start = 1'b1; func = OP_LOAD;
        for (int i = 0; i < 4; i++) begin
            rx = SEL_W'(i); data_in = vals[i];
            @(negedge clk);
            total++;
            if ({busy, done} !== 2'b10 || bus_out !== vals[i]) begin
                bad++;
                $display("FAIL load_t1 #%0d: got busy/done=%b bus=%0d expected 10 bus=%0d",
                         i, {busy, done}, bus_out, vals[i]);
            end
            @(negedge clk);
            if (i == 3) start = 1'b0;
            total++;
            if ({busy, done, err} !== 3'b010) begin
                bad++;
                $display("FAIL load_done #%0d: got busy/done/err=%b expected 010",
                         i, {busy, done, err});
            end
            $display("load R%0d <= %0d done=%b", i, vals[i], done);
        end
        check_regs("load", 3'd3, 3'd5, 3'd4, 3'd1);
    endtask

    // ADD R0,R1: 3+5 = 8 -> 0, carry 1, zero 1; busy exactly 3 cycles.
    task automatic test_add();
        int busy_cnt = 0;
        logic [2:0] exp_bus [3];
        exp_bus = '{3'd3, 3'd5, 3'd0};
        @(negedge clk);
        start = 1'b1; func = OP_ADD; rx = 2'd0; ry = 2'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            total++;
            if (done !== 1'b0 || bus_out !== exp_bus[c]) begin
                bad++;
                $display("FAIL add_T%0d: got done=%b bus=%0d expected done=0 bus=%0d",
                         c + 1, done, bus_out, exp_bus[c]);
            end
        end
        @(negedge clk);
        total++;
        if ({busy, done, err, carry, zero} !== 5'b01011 || busy_cnt != 3) begin
            bad++;
            $display("FAIL add_done: got b/d/e/c/z=%b busy_cycles=%0d expected 01011 busy_cycles=3",
                     {busy, done, err, carry, zero}, busy_cnt);
        end
        $display("add R0=R0+R1 carry=%b zero=%b busy_cycles=%0d", carry, zero, busy_cnt);
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL add_done_width: got done=%b expected 0", done);
        end
        check_regs("add", 3'd0, 3'd5, 3'd4, 3'd1);
    endtask

    // SUB R3,R2 (1-4 = 5, borrow) then XOR R2,R2 (0, zero).
    task automatic test_sub_xor();
        @(negedge clk);
        start = 1'b1; func = OP_SUB; rx = 2'd3; ry = 2'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({done, err, carry, zero} !== 4'b1000) begin
            bad++;
            $display("FAIL sub_done: got d/e/c/z=%b expected 1000", {done, err, carry, zero});
        end
        $display("sub R3=R3-R2 carry=%b zero=%b", carry, zero);
        check_regs("sub", 3'd0, 3'd5, 3'd4, 3'd5);

        @(negedge clk);
        start = 1'b1; func = OP_XOR; rx = 2'd2; ry = 2'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({done, err, carry, zero} !== 4'b1001) begin
            bad++;
            $display("FAIL xor_done: got d/e/c/z=%b expected 1001", {done, err, carry, zero});
        end
        $display("xor R2=R2^R2 carry=%b zero=%b", carry, zero);
        check_regs("xor", 3'd0, 3'd5, 3'd0, 3'd5);
    endtask

    // MOVE R3<-R1, then MOVE R0<-R1 with a start pulse during T1 that must be ignored.
    task automatic test_move_ignore();
        @(negedge clk);
        start = 1'b1; func = OP_MOVE; rx = 2'd3; ry = 2'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({done, err, carry, zero} !== 4'b1001) begin
            bad++;
            $display("FAIL move_flags: got d/e/c/z=%b expected 1001", {done, err, carry, zero});
        end
        $display("move R3<=R1 done=%b", done);

        @(negedge clk);
        start = 1'b1; func = OP_MOVE; rx = 2'd0; ry = 2'd1;
        @(negedge clk);
        // T1: a LOAD R0=7 request here must be dropped.
        total++;
        if (bus_out !== 3'd5 || busy !== 1'b1) begin
            bad++;
            $display("FAIL move_t1: got bus=%0d busy=%b expected bus=5 busy=1", bus_out, busy);
        end
        func = OP_LOAD; rx = 2'd0; data_in = 3'd7;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL move2_done: got done=%b expected 1", done);
        end
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL ignore_start: got busy/done=%b expected 00", {busy, done});
        end
        $display("move R0<=R1 with ignored start, busy=%b done=%b", busy, done);
        check_regs("move", 3'd5, 3'd5, 3'd0, 3'd5);
    endtask

    // Illegal opcode 110: done+err after 2 cycles, nothing written, flags held.
    task automatic test_illegal();
        @(negedge clk);
        start = 1'b1; func = 3'b110; rx = 2'd2; ry = 2'd0; data_in = 3'd6;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({busy, done} !== 2'b10 || bus_out !== 3'd0) begin
            bad++;
            $display("FAIL illegal_t1: got busy/done=%b bus=%0d expected 10 bus=0",
                     {busy, done}, bus_out);
        end
        @(negedge clk);
        total++;
        if ({busy, done, err, carry, zero} !== 5'b01101) begin
            bad++;
            $display("FAIL illegal_done: got b/d/e/c/z=%b expected 01101",
                     {busy, done, err, carry, zero});
        end
        $display("illegal func=110 done=%b err=%b", done, err);
        @(negedge clk);
        total++;
        if ({done, err} !== 2'b00) begin
            bad++;
            $display("FAIL illegal_after: got done/err=%b expected 00", {done, err});
        end
        check_regs("illegal", 3'd5, 3'd5, 3'd0, 3'd5);
    endtask

    // Reset during T2 of ADD R1,R1 aborts it; a following LOAD works.
    task automatic test_reset_midflight();
        @(negedge clk);
        start = 1'b1; func = OP_ADD; rx = 2'd1; ry = 2'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || bus_out !== 3'd5) begin
            bad++;
            $display("FAIL abort_t2: got busy=%b bus=%0d expected busy=1 bus=5", busy, bus_out);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, err, carry, zero} !== 5'b00000 || bus_out !== 3'd0) begin
            bad++;
            $display("FAIL abort_async: got b/d/e/c/z=%b bus=%0d expected 00000 bus=0",
                     {busy, done, err, carry, zero}, bus_out);
        end
        check_regs("abort", 3'd0, 3'd0, 3'd0, 3'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b0;
            total++;
            if ({busy, done} !== 2'b00) begin
                bad++;
                $display("FAIL abort_nodone %0d: got busy/done=%b expected 00", c, {busy, done});
            end
        end
        start = 1'b1; func = OP_LOAD; rx = 2'd2; data_in = 3'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, err} !== 3'b010) begin
            bad++;
            $display("FAIL post_reset_load: got busy/done/err=%b expected 010", {busy, done, err});
        end
        $display("load after reset R2 <= 6 done=%b", done);
        check_regs("post_reset", 3'd0, 3'd0, 3'd6, 3'd0);
    endtask

    initial begin
        test_reset();
        test_load_b2b();
        test_add();
        test_sub_xor();
        test_move_ignore();
        test_illegal();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/param_proc_core.md
# param_proc_core

Parametrised successor to the 4-register, 3-bit bus processor. Integrates the register file, A/G accumulator registers, ALU (add/sub/xor) and multi-cycle control FSM in one block. Internal bus is a multiplexer rather than tri-state buffers. Adds a start/busy/done handshake, ALU flags, illegal-opcode reporting and a debug read port, and sits under the top-level test harness that supplies instructions.

## Interface
- WIDTH, 3, datapath and register width in bits (≥2)
- NUM_REGS, 4, general registers R0..R(NUM_REGS-1); power of two, ≥2
- SEL_W, $clog2(NUM_REGS), register-select width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  instruction request; sampled only in IDLE
- func  in  3  opcode: 000 LOAD, 001 MOVE, 010 ADD, 011 SUB, 100 XOR, 101–111 illegal
- rx  in  SEL_W  destination / first operand register
- ry  in  SEL_W  second operand register
- data_in  in  WIDTH  immediate for LOAD
- busy  out  1  high while an instruction is in progress (state ≠ IDLE)
- done  out  1  one-cycle completion pulse, registered
- err  out  1  valid with done: 1 = illegal opcode
- carry  out  1  ADD carry-out / SUB no-borrow; 0 after XOR
- zero  out  1  last ALU result == 0
- bus_out  out  WIDTH  current internal bus value; 0 when no source drives it
- rd_sel  in  SEL_W  debug read select
- rd_data  out  WIDTH  combinational contents of R[rd_sel]

## Operation
- States: IDLE, T1, T2, T3.
- IDLE:
  - start=1 → latch func/rx/ry/data_in into an instruction register, go to T1.
  - start=0 → stay in IDLE.
- T1:
  - LOAD: bus=data_in, R[rx]←bus, go to IDLE, done=1 next cycle.
  - MOVE: bus=R[ry], R[rx]←bus, go to IDLE, done=1 next cycle.
  - ALU op: bus=R[rx], A←bus, go to T2.
  - Illegal opcode: no write, go to IDLE, done=1 and err=1 next cycle.
- T2: bus=R[ry], G←A op bus, carry and zero updated, go to T3.
- T3: bus=G, R[rx]←bus, go to IDLE, done=1 next cycle.
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH.
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: A + ~B + 1; carry = 1 when A ≥ B.
  - XOR: carry=0.
- Flags change only in T2 and hold otherwise.
- rx==ry is legal. A is captured before G is computed: ADD Rn,Rn doubles, SUB Rn,Rn gives 0 with zero=1 and carry=1, XOR Rn,Rn gives 0.
- start while busy=1 is ignored; there is no queueing.
- err is 0 whenever done is 0.

## Timing
- Accepting edge = the rising edge at which IDLE sees start=1.
- LOAD/MOVE/illegal: destination written at accepting edge +1; done high in the cycle after that.
- ALU ops: A loads at +1, G at +2, R[rx] at +3; done high in the cycle after +3.
- Latency: done asserts 2 cycles (LOAD/MOVE/illegal) or 4 cycles (ALU) after the accepting edge.
- Throughput: the state is already IDLE during the done cycle, so start in that cycle is accepted. Back-to-back instructions therefore cost 2 or 4 cycles each.
- rd_data reflects a register write in the cycle after the write edge.
- Reset, asynchronous at any time:
  - All R[i], A, G and the instruction register clear to 0; state goes to IDLE.
  - busy, done, err, carry and zero all go to 0; bus_out goes to 0.
  - An in-flight instruction is aborted with no register write and no done pulse.
- After rst deasserts, the first accepting edge is the first rising edge with start=1.

## Test plan
- Reset, then LOAD R0=3, R1=5, R2=4, R3=1 back-to-back (start held high) → done every 2 cycles; rd_data reads 3, 5, 4, 1.
- ADD rx=0 ry=1 (3+5, WIDTH=3) → R0=0, carry=1, zero=1, done exactly 4 cycles after acceptance, busy high for 3 cycles.
- SUB rx=3 ry=2 (1−4) → R3=5, carry=0, zero=0. Then XOR rx=2 ry=2 → R2=0, zero=1, carry=0.
- MOVE rx=3 ry=1 → R3=5, flags unchanged. Pulse start mid-instruction → ignored, no extra done.
- func=110 → done with err=1 after 2 cycles; all registers unchanged.
- Assert rst during T2 of ADD rx=1 ry=1 → no done pulse, all registers 0, busy=0 immediately. A following LOAD works normally.
